// File: rtl/decode_stage_if.sv
// Bundle handshake and decoded-output bus between the instruction queue,
// decode_stage and rename/dispatch.
interface decode_stage_if #(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_pc;
  logic [32*WIDTH-1:0]     in_inst;
  logic [WIDTH-1:0]        in_lane_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_lane_valid;
  logic [XLEN*WIDTH-1:0]   out_pc;
  logic [7*WIDTH-1:0]      out_opcode;
  logic [3*WIDTH-1:0]      out_funct3;
  logic [7*WIDTH-1:0]      out_funct7;
  logic [5*WIDTH-1:0]      out_rs1;
  logic [5*WIDTH-1:0]      out_rs2;
  logic [5*WIDTH-1:0]      out_rd;
  logic [32*WIDTH-1:0]     out_imm;
  logic [WIDTH-1:0]        out_uses_rs1;
  logic [WIDTH-1:0]        out_uses_rs2;
  logic [WIDTH-1:0]        out_writes_rd;
  logic [WIDTH-1:0]        out_illegal;
  logic [WIDTH*WIDTH-1:0]  out_dep_rs1;
  logic [WIDTH*WIDTH-1:0]  out_dep_rs2;

  modport master (
    output flush, in_valid, in_pc, in_inst, in_lane_mask, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_pc, out_opcode, out_funct3,
           out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_uses_rs1,
           out_uses_rs2, out_writes_rd, out_illegal, out_dep_rs1, out_dep_rs2
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_lane_mask, out_ready,
    output in_ready, out_valid, out_lane_valid, out_pc, out_opcode, out_funct3,
           out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_uses_rs1,
           out_uses_rs2, out_writes_rd, out_illegal, out_dep_rs1, out_dep_rs2
  );
endinterface

// File: rtl/decode_stage.sv
// Registered N-wide RV32I decode stage: field split, immediate select,
// usage/legality flags, illegal-lane truncation and intra-bundle RAW flags.
module decode_stage #(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [WIDTH-1:0]            lane_valid;
    logic [WIDTH-1:0][XLEN-1:0]  pc;
    logic [WIDTH-1:0][6:0]       opcode;
    logic [WIDTH-1:0][2:0]       funct3;
    logic [WIDTH-1:0][6:0]       funct7;
    logic [WIDTH-1:0][4:0]       rs1;
    logic [WIDTH-1:0][4:0]       rs2;
    logic [WIDTH-1:0][4:0]       rd;
    logic [WIDTH-1:0][31:0]      imm;
    logic [WIDTH-1:0]            uses_rs1;
    logic [WIDTH-1:0]            uses_rs2;
    logic [WIDTH-1:0]            writes_rd;
    logic [WIDTH-1:0]            illegal;
    logic [WIDTH-1:0][WIDTH-1:0] dep_rs1;
    logic [WIDTH-1:0][WIDTH-1:0] dep_rs2;
  } bundle_t;

  bundle_t     dec;
  bundle_t     bundle_d, bundle_q;
  logic        valid_d, valid_q;
  logic        in_ready_c;
  logic        accept;
  logic        seen_illegal;
  logic        legal;
  logic        u1, u2, wr;
  logic [31:0] ins;
  logic [31:0] imm;

  always_comb begin
    dec          = '0;
    seen_illegal = 1'b0;
    ins          = '0;
    legal        = 1'b0;
    u1           = 1'b0;
    u2           = 1'b0;
    wr           = 1'b0;
    imm          = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ins   = bus.in_inst[32*i +: 32];
      legal = 1'b1;
      u1    = 1'b0;
      u2    = 1'b0;
      wr    = 1'b0;
      imm   = '0;
      // Every listed opcode ends in 2'b11, so the default arm also covers
      // compressed/invalid low bits; illegal lanes keep zero imm and flags.
      case (ins[6:0])
        OP_LUI, OP_AUIPC: begin
          imm = {ins[31:12], 12'h000};
          wr  = 1'b1;
        end
        OP_JAL: begin
          imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
          wr  = 1'b1;
        end
        OP_JALR, OP_LOAD, OP_IMM: begin
          imm = {{20{ins[31]}}, ins[31:20]};
          u1  = 1'b1;
          wr  = 1'b1;
        end
        OP_BRANCH: begin
          imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
          u1  = 1'b1;
          u2  = 1'b1;
        end
        OP_STORE: begin
          imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
          u1  = 1'b1;
          u2  = 1'b1;
        end
        OP_OP: begin
          u1 = 1'b1;
          u2 = 1'b1;
          wr = 1'b1;
        end
        default: legal = 1'b0;
      endcase

      // Lanes masked off, or younger than the first illegal lane, stay all-zero.
      if (bus.in_lane_mask[i] && !seen_illegal) begin
        dec.lane_valid[i] = 1'b1;
        dec.pc[i]         = bus.in_pc + (XLEN'(i) << 2);
        dec.opcode[i]     = ins[6:0];
        dec.rd[i]         = ins[11:7];
        dec.funct3[i]     = ins[14:12];
        dec.rs1[i]        = ins[19:15];
        dec.rs2[i]        = ins[24:20];
        dec.funct7[i]     = ins[31:25];
        dec.imm[i]        = imm;
        dec.uses_rs1[i]   = u1;
        dec.uses_rs2[i]   = u2;
        dec.writes_rd[i]  = wr && (ins[11:7] != 5'd0);
        dec.illegal[i]    = !legal;
        seen_illegal      = !legal;
      end
    end

    for (int unsigned i = 1; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < i; j++) begin
        dec.dep_rs1[i][j] = dec.lane_valid[i] && dec.lane_valid[j] && dec.writes_rd[j]
                            && dec.uses_rs1[i] && (dec.rd[j] == dec.rs1[i]);
        dec.dep_rs2[i][j] = dec.lane_valid[i] && dec.lane_valid[j] && dec.writes_rd[j]
                            && dec.uses_rs2[i] && (dec.rd[j] == dec.rs2[i]);
      end
    end
  end

  assign in_ready_c = !rst && !bus.flush && (!valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = valid_q;
  assign bus.out_lane_valid = bundle_q.lane_valid;
  assign bus.out_pc         = bundle_q.pc;
  assign bus.out_opcode     = bundle_q.opcode;
  assign bus.out_funct3     = bundle_q.funct3;
  assign bus.out_funct7     = bundle_q.funct7;
  assign bus.out_rs1        = bundle_q.rs1;
  assign bus.out_rs2        = bundle_q.rs2;
  assign bus.out_rd         = bundle_q.rd;
  assign bus.out_imm        = bundle_q.imm;
  assign bus.out_uses_rs1   = bundle_q.uses_rs1;
  assign bus.out_uses_rs2   = bundle_q.uses_rs2;
  assign bus.out_writes_rd  = bundle_q.writes_rd;
  assign bus.out_illegal    = bundle_q.illegal;
  assign bus.out_dep_rs1    = bundle_q.dep_rs1;
  assign bus.out_dep_rs2    = bundle_q.dep_rs2;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (WIDTH=2): directed scenarios plus a
// randomized handshake run against a behavioural decode model.
module tb_decode_stage;
  localparam int W = 2;
  localparam int X = 32;

  typedef struct packed {
    logic [W-1:0]         lane_valid;
    logic [W-1:0][X-1:0]  pc;
    logic [W-1:0][6:0]    opcode;
    logic [W-1:0][2:0]    funct3;
    logic [W-1:0][6:0]    funct7;
    logic [W-1:0][4:0]    rs1;
    logic [W-1:0][4:0]    rs2;
    logic [W-1:0][4:0]    rd;
    logic [W-1:0][31:0]   imm;
    logic [W-1:0]         uses_rs1;
    logic [W-1:0]         uses_rs2;
    logic [W-1:0]         writes_rd;
    logic [W-1:0]         illegal;
    logic [W*W-1:0]       dep_rs1;
    logic [W*W-1:0]       dep_rs2;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  decode_stage_if #(.WIDTH(W), .XLEN(X)) bus ();
  decode_stage #(.WIDTH(W), .XLEN(X)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [63:0] insts,
                       input logic [1:0] mask);
    bus.in_valid     = v;
    bus.in_pc        = pc;
    bus.in_inst      = insts;
    bus.in_lane_mask = mask;
  endtask

  function automatic bundle_t observe();
    bundle_t b;
    b.lane_valid = bus.out_lane_valid;
    b.pc         = bus.out_pc;
    b.opcode     = bus.out_opcode;
    b.funct3     = bus.out_funct3;
    b.funct7     = bus.out_funct7;
    b.rs1        = bus.out_rs1;
    b.rs2        = bus.out_rs2;
    b.rd         = bus.out_rd;
    b.imm        = bus.out_imm;
    b.uses_rs1   = bus.out_uses_rs1;
    b.uses_rs2   = bus.out_uses_rs2;
    b.writes_rd  = bus.out_writes_rd;
    b.illegal    = bus.out_illegal;
    b.dep_rs1    = bus.out_dep_rs1;
    b.dep_rs2    = bus.out_dep_rs2;
    return b;
  endfunction

  // Reference decode: immediates are rebuilt with signed integer arithmetic.
  function automatic bundle_t model(input logic [31:0] pc, input logic [63:0] insts,
                                    input logic [1:0] mask);
    bundle_t b = '0;
    bit dead = 0;
    for (int i = 0; i < W; i++) begin
      logic [31:0] x;
      int sgn, v;
      bit r1, r2, wd, ok;
      x = insts[32*i +: 32];
      if (!mask[i] || dead) continue;
      sgn = x[31] ? -1 : 0;
      r1 = 0; r2 = 0; wd = 0; ok = 1; v = 0;
      case (x[6:0])
        7'h37, 7'h17: begin v = int'(x & 32'hFFFF_F000); wd = 1; end
        7'h6F: begin
          v = sgn * (1 << 20) + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
          wd = 1;
        end
        7'h67, 7'h03, 7'h13: begin v = sgn * 2048 + int'(x[30:20]); r1 = 1; wd = 1; end
        7'h63: begin
          v = sgn * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
          r1 = 1; r2 = 1;
        end
        7'h23: begin v = sgn * 2048 + int'(x[30:25]) * 32 + int'(x[11:7]); r1 = 1; r2 = 1; end
        7'h33: begin r1 = 1; r2 = 1; wd = 1; end
        default: ok = 0;
      endcase
      b.lane_valid[i] = 1'b1;
      b.pc[i]         = pc + 32'(4 * i);
      b.opcode[i]     = x[6:0];
      b.rd[i]         = x[11:7];
      b.funct3[i]     = x[14:12];
      b.rs1[i]        = x[19:15];
      b.rs2[i]        = x[24:20];
      b.funct7[i]     = x[31:25];
      b.imm[i]        = 32'(v);
      b.uses_rs1[i]   = r1;
      b.uses_rs2[i]   = r2;
      b.writes_rd[i]  = wd && (x[11:7] != 0);
      b.illegal[i]    = !ok;
      if (!ok) dead = 1;
    end
    for (int i = 0; i < W; i++)
      for (int j = 0; j < i; j++)
        if (b.lane_valid[i] && b.lane_valid[j] && b.writes_rd[j]) begin
          b.dep_rs1[i*W+j] = b.uses_rs1[i] && b.rd[j] == b.rs1[i];
          b.dep_rs2[i*W+j] = b.uses_rs2[i] && b.rd[j] == b.rs2[i];
        end
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                             7'h63, 7'h23, 7'h33, 7'h00, 7'h7F};
    logic [31:0] x = $urandom;
    if ($urandom_range(0, 9) != 0) x[6:0] = ops[$urandom_range(0, 10)];
    x[11:7]  = 5'($urandom_range(0, 3));
    x[19:15] = 5'($urandom_range(0, 3));
    x[24:20] = 5'($urandom_range(0, 3));
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    offer(1'b1, 32'h2000, 64'h0010_8133_0050_0093, 2'b11);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    tick(); tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (observe() !== bundle_t'('0)) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", observe());
    end
    rst = 1'b0;
    offer(1'b0, '0, '0, '0);
    tick();
  endtask

  task automatic test_basic();
    offer(1'b1, 32'h1000, {32'h0010_8133, 32'h0050_0093}, 2'b11);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_in_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    offer(1'b0, '0, '0, '0);
    checks++;
    if ({bus.out_valid, bus.out_imm[31:0], bus.out_rd[4:0], bus.out_writes_rd[0]} !==
        {1'b1, 32'd5, 5'd1, 1'b1}) begin
      failures++;
      $display("FAIL basic_lane0 got v=%b imm=%h rd=%0d wr=%b exp v=1 imm=5 rd=1 wr=1",
               bus.out_valid, bus.out_imm[31:0], bus.out_rd[4:0], bus.out_writes_rd[0]);
    end
    checks++;
    if ({bus.out_rs1[9:5], bus.out_rs2[9:5], bus.out_imm[63:32], bus.out_pc[63:32]} !==
        {5'd1, 5'd1, 32'd0, 32'h1004}) begin
      failures++;
      $display("FAIL basic_lane1 got rs1=%0d rs2=%0d imm=%h pc=%h exp 1 1 0 00001004",
               bus.out_rs1[9:5], bus.out_rs2[9:5], bus.out_imm[63:32], bus.out_pc[63:32]);
    end
    checks++;
    if ({bus.out_dep_rs1, bus.out_dep_rs2} !== {4'b0100, 4'b0100}) begin
      failures++;
      $display("FAIL basic_deps got d1=%b d2=%b exp 0100 0100", bus.out_dep_rs1, bus.out_dep_rs2);
    end
    checks++;
    if (observe() !== model(32'h1000, {32'h0010_8133, 32'h0050_0093}, 2'b11)) begin
      failures++; $display("FAIL basic_model got=%h exp=%h", observe(),
                           model(32'h1000, {32'h0010_8133, 32'h0050_0093}, 2'b11));
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_consume got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_store_branch();
    offer(1'b1, 32'h40, {32'hFE00_0CE3, 32'hFE11_2E23}, 2'b11);
    tick();
    offer(1'b0, '0, '0, '0);
    checks++;
    if ({bus.out_imm[31:0], bus.out_uses_rs2[0], bus.out_writes_rd[0], bus.out_imm[63:32]} !==
        {32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFF8}) begin
      failures++;
      $display("FAIL sb_imm got imm0=%h u2=%b wr=%b imm1=%h exp fffffffc 1 0 fffffff8",
               bus.out_imm[31:0], bus.out_uses_rs2[0], bus.out_writes_rd[0], bus.out_imm[63:32]);
    end
    checks++;
    if ({bus.out_dep_rs1, bus.out_dep_rs2} !== 8'h00) begin
      failures++;
      $display("FAIL sb_deps got d1=%b d2=%b exp 0000 0000", bus.out_dep_rs1, bus.out_dep_rs2);
    end
    tick();
  endtask

  task automatic test_illegal();
    offer(1'b1, 32'h80, {32'h0050_0093, 32'h0000_0000}, 2'b11);
    tick();
    offer(1'b0, '0, '0, '0);
    checks++;
    if ({bus.out_illegal[0], bus.out_lane_valid} !== {1'b1, 2'b01}) begin
      failures++;
      $display("FAIL illegal_flags got ill=%b lv=%b exp ill=1 lv=01",
               bus.out_illegal[0], bus.out_lane_valid);
    end
    checks++;
    if ({bus.out_pc[63:32], bus.out_opcode[13:7], bus.out_rd[9:5], bus.out_rs1[9:5],
         bus.out_imm[63:32], bus.out_writes_rd[1], bus.out_uses_rs1[1], bus.out_illegal[1]} !== '0) begin
      failures++;
      $display("FAIL illegal_lane1 got pc=%h op=%h rd=%0d imm=%h wr=%b exp all zero",
               bus.out_pc[63:32], bus.out_opcode[13:7], bus.out_rd[9:5],
               bus.out_imm[63:32], bus.out_writes_rd[1]);
    end
    checks++;
    if ({bus.out_imm[31:0], bus.out_uses_rs1[0], bus.out_writes_rd[0]} !== '0) begin
      failures++;
      $display("FAIL illegal_lane0_flags got imm=%h u1=%b wr=%b exp 0 0 0",
               bus.out_imm[31:0], bus.out_uses_rs1[0], bus.out_writes_rd[0]);
    end
    tick();
  endtask

  task automatic test_zero_mask_wrap();
    offer(1'b1, 32'h10, {32'h0050_0093, 32'h0050_0093}, 2'b00);
    tick();
    checks++;
    if ({bus.out_valid, bus.out_lane_valid, bus.out_imm} !== {1'b1, 2'b00, 64'd0}) begin
      failures++;
      $display("FAIL zero_mask got v=%b lv=%b imm=%h exp v=1 lv=00 imm=0",
               bus.out_valid, bus.out_lane_valid, bus.out_imm);
    end
    offer(1'b1, 32'hFFFF_FFFC, {32'h0000_0013, 32'h0000_0013}, 2'b11);
    tick();
    offer(1'b0, '0, '0, '0);
    checks++;
    if (bus.out_pc !== {32'h0000_0000, 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL pc_wrap got=%h exp=00000000fffffffc", bus.out_pc);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [63:0] a = {32'h0020_81B3, 32'h0030_0113};
    logic [63:0] b = {32'h0041_2023, 32'h0000_0037};
    offer(1'b1, 32'h500, a, 2'b11);
    tick();
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h600, b, 2'b11);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL stall_in_ready cycle=%0d got=%b exp=0", c, bus.in_ready);
      end
      checks++;
      if ({bus.out_valid, observe()} !== {1'b1, model(32'h500, a, 2'b11)}) begin
        failures++; $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, observe(),
                             model(32'h500, a, 2'b11));
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    offer(1'b0, '0, '0, '0);
    checks++;
    if ({bus.out_valid, observe()} !== {1'b1, model(32'h600, b, 2'b11)}) begin
      failures++; $display("FAIL stall_next got=%h exp=%h", observe(), model(32'h600, b, 2'b11));
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL stall_no_dup got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    offer(1'b1, 32'h700, {32'h0000_0013, 32'h0050_0093}, 2'b11);
    tick();
    bus.flush = 1'b1;
    offer(1'b1, 32'h800, {32'h0010_8133, 32'h0050_0093}, 2'b11);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    offer(1'b0, '0, '0, '0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_not_captured got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [63:0] c = {32'h0010_8133, 32'h0050_0093};
    offer(1'b1, 32'h900, {32'h0000_0013, 32'hFFF0_0093}, 2'b11);
    tick();
    bus.out_ready = 1'b0;
    offer(1'b0, '0, '0, '0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_stall_in_ready got=%b exp=0", bus.in_ready);
    end
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_imm} !== 65'd0) begin
      failures++; $display("FAIL rst_stall_drop got v=%b imm=%h exp 0 0", bus.out_valid, bus.out_imm);
    end
    bus.out_ready = 1'b1;
    offer(1'b1, 32'hA00, c, 2'b11);
    tick();
    offer(1'b0, '0, '0, '0);
    checks++;
    if ({bus.out_valid, observe()} !== {1'b1, model(32'hA00, c, 2'b11)}) begin
      failures++; $display("FAIL rst_resume got=%h exp=%h", observe(), model(32'hA00, c, 2'b11));
    end
    tick();
  endtask

  task automatic test_random();
    bit      exp_valid = 0, nv, exp_ready;
    bundle_t exp_b = '0, nb;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid     = $urandom_range(0, 3) != 0;
      bus.out_ready    = $urandom_range(0, 3) != 0;
      bus.flush        = $urandom_range(0, 15) == 0;
      bus.in_pc        = $urandom;
      bus.in_inst      = {rand_inst(), rand_inst()};
      bus.in_lane_mask = 2'($urandom_range(0, 3));
      #1;
      exp_ready = !bus.flush && (!exp_valid || bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_ready) begin
        failures++; $display("FAIL rand_in_ready cycle=%0d got=%b exp=%b", c, bus.in_ready, exp_ready);
      end
      nv = exp_valid;
      nb = exp_b;
      if (bus.flush) nv = 0;
      else if (bus.in_valid && exp_ready) begin
        nv = 1;
        nb = model(bus.in_pc, bus.in_inst, bus.in_lane_mask);
      end else if (bus.out_ready) nv = 0;
      tick();
      exp_valid = nv;
      exp_b = nb;
      checks++;
      if (bus.out_valid !== exp_valid) begin
        failures++; $display("FAIL rand_out_valid cycle=%0d got=%b exp=%b", c, bus.out_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (observe() !== exp_b) begin
          failures++; $display("FAIL rand_bundle cycle=%0d got=%h exp=%h", c, observe(), exp_b);
        end
      end
    end
    bus.flush = 1'b0;
    offer(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_store_branch();
    test_illegal();
    test_zero_mask_wrap();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered N-wide instruction decode stage for the superscalar core. It sits between the instruction queue and rename/dispatch. Each cycle it accepts a fetch bundle of up to WIDTH instructions and splits every lane into its fields. It selects each lane's immediate by opcode, derives register-usage and legality flags, and flags RAW dependences between lanes of the same bundle. Results are held in one pipeline register with a valid/ready handshake and flush.

## Interface
- WIDTH, 2, number of lanes per bundle (1..4)
- XLEN, 32, PC width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard the held bundle; refuse input this cycle
- in_valid  in  1  bundle offered
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_pc  in  XLEN  PC of lane 0; lane i PC = in_pc + 4*i
- in_inst  in  32*WIDTH  lane i in bits [32*i+31:32*i]
- in_lane_mask  in  WIDTH  per-lane valid; lane 0 is the oldest lane
- out_valid  out  1  registered bundle present
- out_ready  in  1  consumer takes bundle when out_valid && out_ready
- out_lane_valid  out  WIDTH  per-lane valid after illegal truncation
- out_pc  out  XLEN*WIDTH  per-lane PC
- out_opcode / out_funct3 / out_funct7  out  7/3/7 ×WIDTH  raw fields
- out_rs1 / out_rs2 / out_rd  out  5×WIDTH each  register specifiers
- out_imm  out  32*WIDTH  selected sign-extended immediate
- out_uses_rs1 / out_uses_rs2 / out_writes_rd / out_illegal  out  WIDTH each
- out_dep_rs1 / out_dep_rs2  out  WIDTH*WIDTH  bit [i*WIDTH+j]: lane i source depends on lane j

## Operation
- Field split, per lane: opcode = [6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7 = [31:25].
- Immediate by opcode, standard RV32I I/S/B/U/J formats:
  - U (0110111 LUI, 0010111 AUIPC) = {inst[31:12], 12'h000}.
  - J (1101111 JAL).
  - I (1100111 JALR, 0000011 LOAD, 0010011 OP-IMM).
  - B (1100011).
  - S (0100011).
  - OP (0110011) → 0.
- uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- uses_rs2: BRANCH, STORE, OP.
- writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd != 0.
- illegal: inst[1:0] != 2'b11 or opcode not listed above. An illegal lane has uses_rs1, uses_rs2 and writes_rd forced to 0; imm = 0.
- Truncation: the first masked-in illegal lane k stays valid with illegal = 1. All lanes above k get out_lane_valid = 0.
- Dependence: dep_rs1[i][j] = 1 iff all of the following hold; all other bits (j ≥ i) are 0. dep_rs2 is the same rule using rs2.
  - j < i
  - both lanes valid after truncation
  - writes_rd[j]
  - rd[j] == rs1[i]
  - uses_rs1[i]
- Masked-off lanes: all decoded outputs 0.

## Timing
- Latency 1 cycle: bundle accepted at edge t is on out_* from t+1.
- in_ready = !flush && (!out_valid || out_ready). This is combinational and allows back-to-back bundles at full rate.
- Hold: while out_valid && !out_ready, all out_* are stable.
- Flush: at the next edge out_valid = 0 and no input is captured, even if in_valid = 1. Flush has priority over accept and consume.
- Consume without a new accept: out_valid goes to 0 at the next edge.
- An all-zero in_lane_mask with in_valid = 1 is accepted: out_valid = 1, out_lane_valid = 0.
- Reset: out_valid = 0 and all registered outputs = 0 at the next edge. Reset mid-stall drops the held bundle. in_ready is 0 while rst is high.
- PC lane arithmetic is modulo 2^XLEN; wrap-around is not flagged.

## Test plan
- WIDTH=2, pc=0x1000, insts {0x00500093 addi x1,x0,5 ; 0x00108133 add x2,x1,x1}, mask 2'b11 -> next cycle:
  - lane0 imm = 5, rd = 1, writes_rd = 1.
  - lane1 rs1 = rs2 = 1, imm = 0, pc = 0x1004.
  - dep_rs1 bit[2] = 1, dep_rs2 bit[2] = 1.
- Lane0 0xFE112E23 (sw x1,-4(x2)), lane1 0xFE000CE3 (beq x0,x0,-8) -> lane0 imm = 0xFFFFFFFC with uses_rs2 = 1 and writes_rd = 0; lane1 imm = 0xFFFFFFF8; all dep bits 0.
- Lane0 0x00000000, lane1 0x00500093 -> lane0 illegal = 1; out_lane_valid = 2'b01; lane1 outputs all 0.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and out_* unchanged. Then raise out_ready -> the next bundle appears one cycle later with no loss or duplication.
- Assert flush while out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle; the offered bundle is not captured (in_ready = 0 that cycle).
- Pulse rst while a bundle is stalled -> out_valid = 0 and out_imm = 0 next cycle; normal flow resumes on the first accept after rst deasserts.
